// File: rtl/screen_transition_pkg.sv
// Shared types and constants for the screen transition block.
package screen_pkg;

  typedef enum logic [2:0] {
    SHOW_START = 3'd0,
    FADE_OUT   = 3'd1,
    BLACK_HOLD = 3'd2,
    FADE_IN    = 3'd3,
    SHOW_GAME  = 3'd4
  } state_e;

  localparam int unsigned LEVEL_MAX = 16;
  localparam int unsigned LEVEL_W   = 5;

  localparam int unsigned PIX_W = 16;
  localparam int unsigned R_W   = 5;
  localparam int unsigned G_W   = 6;
  localparam int unsigned B_W   = 5;
  localparam int unsigned R_LSB = 11;
  localparam int unsigned G_LSB = 5;
  localparam int unsigned B_LSB = 0;

endpackage

// File: rtl/screen_transition_if.sv
// Pixel, request and status signals between the screen sources, OLED driver and transition block.
interface screen_transition_if;
  import screen_pkg::*;

  logic             frame_begin;
  logic             start_req;
  logic             restart_req;
  logic [PIX_W-1:0] start_data;
  logic [PIX_W-1:0] game_data;
  logic [PIX_W-1:0] oled_data;
  logic             sel_game;
  logic             busy;

  modport master (
    output frame_begin, start_req, restart_req, start_data, game_data,
    input  oled_data, sel_game, busy
  );

  modport slave (
    input  frame_begin, start_req, restart_req, start_data, game_data,
    output oled_data, sel_game, busy
  );

endinterface

// File: rtl/screen_transition_scale.sv
// Combinational RGB565 brightness scaler: each channel times level/16, truncated.
module rgb565_scale
  import screen_pkg::*;
(
  input  logic [PIX_W-1:0]   pixel,
  input  logic [LEVEL_W-1:0] level,
  output logic [PIX_W-1:0]   scaled
);

  // Per-channel multiply then drop the four fractional bits.
  always_comb begin
    scaled = '0;
    scaled[R_LSB +: R_W] = R_W'(({4'b0, pixel[R_LSB +: R_W]} * {4'b0, level}) >> 4);
    scaled[G_LSB +: G_W] = G_W'(({4'b0, pixel[G_LSB +: G_W]} * {5'b0, level}) >> 4);
    scaled[B_LSB +: B_W] = B_W'(({4'b0, pixel[B_LSB +: B_W]} * {4'b0, level}) >> 4);
  end

endmodule

// File: rtl/screen_transition.sv
// Frame-synchronised fade-out / black hold / fade-in between start and game screens.
module screen_transition
  import screen_pkg::*;
#(
  parameter int unsigned FADE_STEP_FRAMES = 2,
  parameter int unsigned HOLD_FRAMES      = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  screen_transition_if.slave  bus
);

  localparam logic [7:0] STEP_LAST = 8'(FADE_STEP_FRAMES - 1);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_FRAMES - 1);
  localparam logic [LEVEL_W-1:0] LVL_FULL = LEVEL_W'(LEVEL_MAX);

  state_e             state;
  logic [LEVEL_W-1:0] level;
  logic [7:0]         cnt;
  logic               sel;
  logic               busy_q;
  logic [PIX_W-1:0]   src;
  logic [PIX_W-1:0]   scaled;
  logic [PIX_W-1:0]   oled_q;

  // Transition sequencer; level and sel share this register stage so mux and scale switch together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= SHOW_START;
      level  <= LVL_FULL;
      cnt    <= '0;
      sel    <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        SHOW_START: begin
          if (bus.start_req) begin
            state  <= FADE_OUT;
            cnt    <= '0;
            busy_q <= 1'b1;
          end
        end
        SHOW_GAME: begin
          if (bus.restart_req) begin
            state  <= FADE_OUT;
            cnt    <= '0;
            busy_q <= 1'b1;
          end
        end
        FADE_OUT: begin
          if (bus.frame_begin) begin
            if (cnt == STEP_LAST) begin
              cnt   <= '0;
              level <= level - 1'b1;
              if (level == LEVEL_W'(1)) begin
                state <= BLACK_HOLD;
                sel   <= ~sel;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        BLACK_HOLD: begin
          if (bus.frame_begin) begin
            if (cnt == HOLD_LAST) begin
              cnt   <= '0;
              state <= FADE_IN;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        FADE_IN: begin
          if (bus.frame_begin) begin
            if (cnt == STEP_LAST) begin
              cnt   <= '0;
              level <= level + 1'b1;
              if (level == LVL_FULL - 1'b1) begin
                state  <= sel ? SHOW_GAME : SHOW_START;
                busy_q <= 1'b0;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= SHOW_START;
      endcase
    end
  end

  // Source select ahead of the scaler.
  always_comb begin
    src = sel ? bus.game_data : bus.start_data;
  end

  rgb565_scale u_scale (
    .pixel  (src),
    .level  (level),
    .scaled (scaled)
  );

  // Output pixel register: one clock from the data inputs to the OLED.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) oled_q <= '0;
    else        oled_q <= scaled;
  end

  assign bus.oled_data = oled_q;
  assign bus.sel_game  = sel;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_screen_transition.sv
// Self-checking bench: directed test-plan sequences plus random requests against a frame-count model.
module tb_screen_transition;

  localparam int FS    = 2;
  localparam int HOLD  = 8;
  localparam int FO    = 16 * FS;
  localparam int TOTAL = 32 * FS + HOLD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  screen_transition_if bus ();

  screen_transition #(.FADE_STEP_FRAMES(FS), .HOLD_FRAMES(HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: whether a transition is running, counted frames since it was accepted, resting source.
  bit m_active = 0;
  int m_f      = 0;
  bit m_base   = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_level();
    if (!m_active)          return 16;
    if (m_f < FO)           return 16 - m_f / FS;
    if (m_f < FO + HOLD)    return 0;
    if (m_f < TOTAL)        return (m_f - FO - HOLD) / FS;
    return 16;
  endfunction

  function automatic bit m_sel();
    return m_base ^ (m_active && m_f >= FO);
  endfunction

  function automatic logic [15:0] ref_scale(input logic [15:0] px, input int lvl);
    int r, g, b;
    r = px[15:11];
    g = px[10:5];
    b = px[4:0];
    return {5'((r * lvl) / 16), 6'((g * lvl) / 16), 5'((b * lvl) / 16)};
  endfunction

  task automatic model_reset();
    m_active = 0;
    m_f      = 0;
    m_base   = 0;
  endtask

  // One clock with given inputs; checks outputs 1 time unit after the edge.
  task automatic step(input logic fb, input logic sr, input logic rr,
                      input logic [15:0] sd, input logic [15:0] gd);
    logic [15:0] exp_oled;
    bus.frame_begin = fb;
    bus.start_req   = sr;
    bus.restart_req = rr;
    bus.start_data  = sd;
    bus.game_data   = gd;
    exp_oled = ref_scale(m_sel() ? gd : sd, m_level());
    if (!m_active) begin
      if ((sr && !m_base) || (rr && m_base)) begin
        m_active = 1;
        m_f      = 0;
      end
    end else if (fb) begin
      m_f++;
      if (m_f == TOTAL) begin
        m_active = 0;
        m_f      = 0;
        m_base   = ~m_base;
      end
    end
    @(posedge clk);
    #1;
    check("oled", bus.oled_data, exp_oled);
    check("sel",  {15'b0, bus.sel_game}, {15'b0, m_sel()});
    check("busy", {15'b0, bus.busy},     {15'b0, m_active});
    bus.frame_begin = 1'b0;
    bus.start_req   = 1'b0;
    bus.restart_req = 1'b0;
  endtask

  // n frame_begin pulses, each followed by two idle cycles.
  task automatic frames(input int n, input logic [15:0] sd, input logic [15:0] gd);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, 1'b0, sd, gd);
      step(1'b0, 1'b0, 1'b0, sd, gd);
      step(1'b0, 1'b0, 1'b0, sd, gd);
    end
  endtask

  initial begin
    bus.frame_begin = 1'b0;
    bus.start_req   = 1'b0;
    bus.restart_req = 1'b0;
    bus.start_data  = 16'hFFFF;
    bus.game_data   = 16'h0000;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_oled", bus.oled_data, 16'h0000);
    check("rst_sel",  {15'b0, bus.sel_game}, 16'h0000);
    check("rst_busy", {15'b0, bus.busy},     16'h0000);
    rst_n = 1'b1;
    model_reset();

    // Passthrough in SHOW_START; restart_req ignored there
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h1234);
    check("pass_ffff", bus.oled_data, 16'hFFFF);
    step(1'b1, 1'b0, 1'b1, 16'hFFFF, 16'h1234);
    step(1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h1234);
    check("restart_ign", {15'b0, bus.busy}, 16'h0000);

    // start_req coinciding with frame_begin: that pulse does not count
    step(1'b1, 1'b1, 1'b0, 16'hFFFF, 16'h1234);
    frames(1, 16'hFFFF, 16'h1234);
    check("lvl16_after1", bus.oled_data, 16'hFFFF);
    frames(1, 16'hFFFF, 16'h1234);
    step(1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h1234);
    check("lvl15_after2", bus.oled_data, 16'hEF7D);

    // Repeated start_req mid fade-out changes nothing
    step(1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h1234);
    frames(14, 16'hFFFF, 16'h1234);
    step(1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h1234);
    check("lvl8_ffff", bus.oled_data, 16'h7BEF);
    step(1'b0, 1'b0, 1'b0, 16'hF800, 16'h1234);
    check("lvl8_f800", bus.oled_data, 16'h7800);

    // Into BLACK_HOLD (frame 36)
    frames(20, 16'hFFFF, 16'h1234);
    check("hold_black", bus.oled_data, 16'h0000);
    check("hold_sel",   {15'b0, bus.sel_game}, 16'h0001);

    // Asynchronous reset mid-hold
    #2 rst_n = 1'b0;
    #1;
    check("arst_oled", bus.oled_data, 16'h0000);
    check("arst_sel",  {15'b0, bus.sel_game}, 16'h0000);
    check("arst_busy", {15'b0, bus.busy},     16'h0000);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    step(1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h1234);
    step(1'b0, 1'b0, 1'b0, 16'hA5C3, 16'h1234);
    check("post_rst_pass", bus.oled_data, 16'hA5C3);

    // Full start -> game transition
    step(1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h1234);
    frames(FO, 16'hFFFF, 16'h1234);
    check("f32_black", bus.oled_data, 16'h0000);
    check("f32_sel",   {15'b0, bus.sel_game}, 16'h0001);
    frames(HOLD, 16'hFFFF, 16'h1234);
    check("f40_black", bus.oled_data, 16'h0000);
    frames(FO - 1, 16'hFFFF, 16'h1234);
    check("f71_busy", {15'b0, bus.busy}, 16'h0001);
    frames(1, 16'hFFFF, 16'h1234);
    check("f72_busy", {15'b0, bus.busy}, 16'h0000);
    step(1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h1234);
    check("game_pass", bus.oled_data, 16'h1234);
    step(1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h1234);
    check("start_ign_game", {15'b0, bus.busy}, 16'h0000);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 3) == 0,
           $urandom_range(0, 60) == 0,
           $urandom_range(0, 60) == 0,
           16'($urandom), 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/screen_transition.md
Name: screen_transition

Overview:
- Sits directly downstream of the start-screen image stage and the game renderer, and directly upstream of the OLED driver's pixel_data input.
- Selects which screen's 16-bit RGB565 pixel reaches the OLED.
- On a request, performs a frame-synchronised fade-out, black hold and fade-in between the start screen and the game screen.
- Brightness changes only at frame boundaries, so no tearing occurs within a frame.

Parameters:
- FADE_STEP_FRAMES, 2, frames per brightness level step (1..15).
- HOLD_FRAMES, 8, frames held at black between fade-out and fade-in (1..255).

Ports:
- clk  input  1  system pixel clock, same clock as the image ROM stages.
- rst_n  input  1  asynchronous, active-low reset.
- frame_begin  input  1  one-cycle pulse from the OLED driver at the start of each frame.
- start_req  input  1  one-cycle pulse (debounced button): go from start screen to game.
- restart_req  input  1  one-cycle pulse: go from game back to start screen.
- start_data  input  16  RGB565 pixel from the start-screen stage.
- game_data  input  16  RGB565 pixel from the game renderer.
- oled_data  output  16  scaled RGB565 pixel to the OLED driver.
- sel_game  output  1  1 = game source selected.
- busy  output  1  high while a transition is in progress.

Behaviour:
- Reset (async assert, sync release): state SHOW_START, level=16, frame counter=0, sel_game=0, busy=0, oled_data=16'h0000.
- Level range: 0..16. Level 16 is passthrough; level 0 is black.
- States:
  - SHOW_START: start_req -> FADE_OUT; restart_req ignored.
  - FADE_OUT: on each frame_begin, counter++. When counter==FADE_STEP_FRAMES-1: counter clears and level--. When level reaches 0 -> BLACK_HOLD, and sel_game toggles in that same cycle.
  - BLACK_HOLD: count HOLD_FRAMES frame_begin pulses, then -> FADE_IN with counter=0.
  - FADE_IN: same stepping as FADE_OUT but level++. At level 16 -> SHOW_GAME if sel_game=1, else SHOW_START.
  - SHOW_GAME: restart_req -> FADE_OUT; start_req ignored.
- busy = 1 in FADE_OUT, BLACK_HOLD and FADE_IN; it is registered and rises the cycle after the request is accepted.
- Any start_req or restart_req while busy is ignored and not queued.
- Request coinciding with frame_begin: the request is accepted. That frame_begin does not count; the first count occurs at the next frame_begin.
- start_req and restart_req asserted together: only the one valid in the current stable state acts.
- Full fade-out duration: 16*FADE_STEP_FRAMES frames; total transition = 32*FADE_STEP_FRAMES + HOLD_FRAMES frames.
- Pixel path:
  - src = sel_game ? game_data : start_data.
  - R5' = (R5*level)>>4, G6' = (G6*level)>>4, B5' = (B5*level)>>4, computed with unsigned truncation and no rounding.
  - Result is registered into oled_data, giving exactly 1 clk latency from the data inputs.
  - The driver's pixel_index must account for the upstream 3-cycle ROM latency plus this 1 cycle.
- Level and sel_game are updated in the same register stage, so the mux and scale change atomically between pixels.
- Reset mid-transition: immediate return to SHOW_START at full brightness.

Decomposition:
- Package screen_pkg holds:
  - the state enum (SHOW_START, FADE_OUT, BLACK_HOLD, FADE_IN, SHOW_GAME);
  - LEVEL_MAX=16 and LEVEL_W=5;
  - RGB565 field widths and positions.
- Sub-module rgb565_scale: purely combinational, inputs 16-bit pixel and 5-bit level, output 16-bit scaled pixel. The top registers its output.

Test Plan:
- Reset, start_data=16'hFFFF, no requests -> oled_data=16'hFFFF one clk later, sel_game=0, busy=0 indefinitely.
- start_req, FADE_STEP_FRAMES=2 -> level=8 after 16 frame_begins. Checks:
  - start_data=16'hFFFF -> oled_data=16'h7BEF.
  - start_data=16'hF800 -> 16'h7800.
- Full start->game transition, HOLD_FRAMES=8:
  - oled_data=16'h0000 and sel_game=1 from frame 32 through frame 40.
  - At frame 72: busy falls, state SHOW_GAME, game_data passes through unchanged.
- start_req repeated during FADE_OUT, and restart_req in SHOW_START -> no timing change, no extra transition.
- start_req on the same cycle as frame_begin -> the first level decrement occurs only after the next two further frame_begins.
- rst_n pulled low during BLACK_HOLD -> asynchronously oled_data=0, sel_game=0, busy=0. After release: SHOW_START passthrough at level 16.
